apb_cfg_master: RTL and testbench

APB_CFG_MASTER -- requirements
Module: apb_cfg_master

---
 rtl/apb_cfg_master_pkg.sv | 25 ++
 rtl/apb_cfg_master_cmd_fifo.sv | 68 ++++++
 rtl/apb_cfg_master.sv | 140 ++++++++++++++
 tb/tb_apb_cfg_master.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_cfg_master_pkg.sv
// Shared definitions for the APB configuration master: FSM encoding, command
// layout and default parameter values.
package apb_cfg_master_pkg;

    localparam int unsigned DEF_ADDR_WIDTH     = 4;
    localparam int unsigned DEF_DATA_WIDTH     = 4;
    localparam int unsigned DEF_FIFO_DEPTH     = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    // Command layout at the default widths; the master builds the same layout
    // from its own ADDR_WIDTH/DATA_WIDTH.
    typedef struct packed {
        logic                      write;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/apb_cfg_master_cmd_fifo.sv
// Command queue: power-of-two FIFO with wrap-around pointers and an occupancy
// count. Full/empty are decoded from the registered count only.
module cmd_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             pclk_i,
    input  logic             prst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: storage carries no reset; count_q alone decides which entries are live.
    always_ff @(posedge pclk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/apb_cfg_master.sv
// APB-style configuration master: queues commands and runs them one at a time
// through SETUP/ACCESS/RESP with a bounded wait for pready_i.
module apb_cfg_master
    import apb_cfg_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  pclk_i,
    input  logic                  prst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_error_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  pwrite_o,
    output logic                  penable_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  perror_i
);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } entry_t;

    localparam int unsigned       WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    apb_state_t            state_q;
    logic [WAIT_W-1:0]     wait_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  pwrite_q;
    logic                  penable_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_error_q;

    entry_t push_entry;
    entry_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_push;
    logic   fifo_pop;

    assign push_entry = '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
    assign fifo_push  = cmd_valid_i && cmd_ready_o;
    assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;

    cmd_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .pclk_i      (pclk_i),
        .prst_n_i    (prst_n_i),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        paddr_q  <= head.addr;
                        pwdata_q <= head.wdata;
                        pwrite_q <= head.write;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    wait_q    <= '0;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // wait_q counts stalled ACCESS cycles already spent; the last
                    // allowed stall ends the transfer with an error.
                    if (pready_i) begin
                        rsp_rdata_q <= pwrite_q ? '0 : prdata_i;
                        rsp_error_q <= perror_i;
                        rsp_valid_q <= 1'b1;
                        penable_q   <= 1'b0;
                        state_q     <= ST_RESP;
                    end else if (wait_q == WAIT_LAST) begin
                        rsp_rdata_q <= '0;
                        rsp_error_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        penable_q   <= 1'b0;
                        state_q     <= ST_RESP;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_RESP: begin
                    pwrite_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o = !fifo_full;
    assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign pwrite_o    = pwrite_q;
    assign penable_o   = penable_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_error_o = rsp_error_q;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Self-checking bench for apb_cfg_master: transaction-level model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_apb_cfg_master;
    import apb_cfg_master_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          pclk = 1'b0;
    logic          prst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          busy;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pwrite;
    logic          penable;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          perror = 1'b0;

    apb_cfg_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .pclk_i      (pclk),
        .prst_n_i    (prst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_write_i (cmd_write),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_error_o (rsp_error),
        .busy_o      (busy),
        .paddr_o     (paddr),
        .pwdata_o    (pwdata),
        .pwrite_o    (pwrite),
        .penable_o   (penable),
        .prdata_i    (prdata),
        .pready_i    (pready),
        .perror_i    (perror)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A transfer is tracked by its cycle index since the pop: index 0 is the
    // setup cycle, indices 1..TMO are access cycles, then one response cycle.
    cmd_t          mq[$];
    cmd_t          m_cur;
    cmd_t          m_new;
    bit            m_push;
    bit            m_active = 0;
    bit            m_in_resp = 0;
    int            m_idx = 0;
    int            m_resp_cnt = 0;
    logic [AW-1:0] e_paddr = '0;
    logic [DW-1:0] e_pwdata = '0;
    logic          e_pwrite = 1'b0;
    logic          e_penable = 1'b0;
    logic          e_rsp_valid = 1'b0;
    logic [DW-1:0] e_rsp_rdata = '0;
    logic          e_rsp_error = 1'b0;

    task automatic m_respond(input logic [DW-1:0] data, input logic err);
        e_rsp_valid = 1'b1;
        e_rsp_rdata = data;
        e_rsp_error = err;
        e_penable   = 1'b0;
        m_in_resp   = 1;
        m_resp_cnt++;
    endtask

    initial forever begin
        @(posedge pclk or negedge prst_n);
        if (!prst_n) begin
            mq.delete();
            m_active = 0; m_in_resp = 0; m_idx = 0;
            e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0; e_penable = 1'b0;
            e_rsp_valid = 1'b0; e_rsp_rdata = '0; e_rsp_error = 1'b0;
        end else begin
            m_push = (cmd_valid === 1'b1) && (mq.size() != DEPTH);
            m_new  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
            e_rsp_valid = 1'b0;
            if (m_active) begin
                if (m_in_resp) begin
                    m_active = 0; m_in_resp = 0; e_pwrite = 1'b0;
                end else if (m_idx == 0) begin
                    m_idx = 1; e_penable = 1'b1;
                end else if (pready === 1'b1) begin
                    m_respond(m_cur.write ? '0 : prdata, perror);
                end else if (m_idx == TMO) begin
                    m_respond('0, 1'b1);
                end else begin
                    m_idx++;
                end
            end else if (mq.size() != 0) begin
                m_cur    = mq.pop_front();
                m_active = 1; m_idx = 0;
                e_paddr  = m_cur.addr; e_pwdata = m_cur.wdata; e_pwrite = m_cur.write;
            end
            if (m_push) mq.push_back(m_new);
        end
    end

    // ---------------- per-cycle comparison ----------------
    bit cmp_en = 0;
    int dut_rsp_cnt = 0;

    initial forever begin
        @(negedge pclk);
        if (cmp_en) begin
            check("cmd_ready_o", 32'(cmd_ready), 32'(mq.size() != DEPTH));
            check("busy_o",      32'(busy),      32'(m_active || mq.size() != 0));
            check("paddr_o",     32'(paddr),     32'(e_paddr));
            check("pwdata_o",    32'(pwdata),    32'(e_pwdata));
            check("pwrite_o",    32'(pwrite),    32'(e_pwrite));
            check("penable_o",   32'(penable),   32'(e_penable));
            check("rsp_valid_o", 32'(rsp_valid), 32'(e_rsp_valid));
            check("rsp_rdata_o", 32'(rsp_rdata), 32'(e_rsp_rdata));
            check("rsp_error_o", 32'(rsp_error), 32'(e_rsp_error));
            if (rsp_valid === 1'b1) dut_rsp_cnt++;
        end
    end

    // ---------------- responder ----------------
    // 0: always ready; 1: ready after rs_waits stalled access cycles;
    // 2: never ready; 3: random with rs_pct percent ready probability.
    int            rs_mode = 0;
    int            rs_waits = 0;
    int            rs_pct = 50;
    logic          rs_err = 1'b0;
    logic [DW-1:0] rs_data = '0;
    int            acc_idx = 0;

    initial forever begin
        @(negedge pclk);
        if (penable === 1'b1) acc_idx++; else acc_idx = 0;
        case (rs_mode)
            0: begin pready = 1'b1; perror = rs_err; prdata = rs_data; end
            1: begin pready = (acc_idx > rs_waits); perror = rs_err; prdata = rs_data; end
            2: begin pready = 1'b0; perror = 1'b1; prdata = DW'($urandom); end
            default: begin
                pready = ($urandom_range(0, 99) < rs_pct);
                perror = ($urandom_range(0, 7) == 0);
                prdata = DW'($urandom);
            end
        endcase
    end

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int guard;
        guard = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (cmd_ready !== 1'b1 && guard < 200) begin
            @(negedge pclk);
            guard++;
        end
        if (guard == 200) check("push_accept_timeout", 32'(cmd_ready), 32'd1);
        @(negedge pclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            @(negedge pclk);
            n++;
        end
        if (n == 100) check(name, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge pclk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_penable",   32'(penable),   32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        prst_n = 1'b1;
        cmp_en = 1;
        @(negedge pclk);

        // Write addr=3 data=9, responder always ready.
        rs_mode = 0;
        push_cmd(1'b1, 4'd3, 4'd9);
        check("wr_busy_queued", 32'(busy), 32'd1);
        @(negedge pclk);
        check("wr_setup_paddr",   32'(paddr),   32'd3);
        check("wr_setup_pwdata",  32'(pwdata),  32'd9);
        check("wr_setup_pwrite",  32'(pwrite),  32'd1);
        check("wr_setup_penable", 32'(penable), 32'd0);
        @(negedge pclk);
        check("wr_access_penable", 32'(penable), 32'd1);
        check("wr_access_paddr",   32'(paddr),   32'd3);
        @(negedge pclk);
        check("wr_resp_valid", 32'(rsp_valid), 32'd1);
        check("wr_resp_error", 32'(rsp_error), 32'd0);
        check("wr_resp_rdata", 32'(rsp_rdata), 32'd0);
        @(negedge pclk);
        check("wr_idle_valid",  32'(rsp_valid), 32'd0);
        check("wr_idle_pwrite", 32'(pwrite),    32'd0);
        check("wr_idle_busy",   32'(busy),      32'd0);

        // Read addr=5, two stalled access cycles, prdata=0xA.
        rs_mode = 1; rs_waits = 2; rs_data = 4'hA;
        push_cmd(1'b0, 4'd5, 4'd3);
        @(negedge pclk);
        check("rd_setup_paddr",   32'(paddr),   32'd5);
        check("rd_setup_penable", 32'(penable), 32'd0);
        wait_rsp("rd_rsp_timeout", n);
        // RESP is the fifth cycle of the transfer counting SETUP as the first.
        check("rd_setup_to_resp", 32'(n),         32'd4);
        check("rd_rdata",         32'(rsp_rdata), 32'hA);
        check("rd_error",         32'(rsp_error), 32'd0);
        @(negedge pclk);

        // perror with pready on a read.
        rs_mode = 0; rs_err = 1'b1; rs_data = 4'h6;
        push_cmd(1'b0, 4'd7, 4'd0);
        wait_rsp("perr_rsp_timeout", n);
        check("perr_error", 32'(rsp_error), 32'd1);
        check("perr_rdata", 32'(rsp_rdata), 32'h6);
        rs_err = 1'b0;
        @(negedge pclk);

        // One transfer stuck until timeout while five more commands are offered.
        rs_mode = 2;
        push_cmd(1'b1, 4'd1, 4'd1);
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    push_cmd(1'b0, AW'(i + 1), DW'(i));
                    if (i == 4) check("full_ready_low", 32'(cmd_ready), 32'd0);
                end
            end
            begin
                int w;
                int acc;
                w = 0;
                while (penable !== 1'b1 && w < 20) begin @(negedge pclk); w++; end
                acc = 0;
                while (rsp_valid !== 1'b1 && acc < 100) begin
                    if (penable === 1'b1) acc++;
                    @(negedge pclk);
                end
                check("tmo_access_cycles", 32'(acc),       32'd16);
                check("tmo_error",         32'(rsp_error), 32'd1);
                check("tmo_rdata",         32'(rsp_rdata), 32'd0);
                rs_mode = 0;
            end
        join
        wait_rsp("next_rsp_timeout", n);
        check("next_paddr", 32'(paddr),     32'd2);
        check("next_error", 32'(rsp_error), 32'd0);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin @(negedge pclk); n++; end
        check("drain_busy", 32'(busy), 32'd0);

        // Reset during ACCESS with two commands queued.
        rs_mode = 2;
        push_cmd(1'b1, 4'd8, 4'd1);
        push_cmd(1'b0, 4'd9, 4'd0);
        push_cmd(1'b1, 4'd10, 4'd2);
        check("pre_rst_penable", 32'(penable), 32'd1);
        check("pre_rst_busy",    32'(busy),    32'd1);
        #2 prst_n = 1'b0;
        #1;
        check("arst_paddr",     32'(paddr),     32'd0);
        check("arst_pwdata",    32'(pwdata),    32'd0);
        check("arst_pwrite",    32'(pwrite),    32'd0);
        check("arst_penable",   32'(penable),   32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("arst_rsp_error", 32'(rsp_error), 32'd0);
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge pclk);
        @(negedge pclk);
        prst_n = 1'b1;
        rs_mode = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("post_rst_busy",      32'(busy),      32'd0);
        end

        // Randomized traffic at decreasing responder readiness.
        rs_mode = 3;
        for (int s = 0; s < 3; s++) begin
            rs_pct = (s == 0) ? 70 : (s == 1) ? 25 : 4;
            repeat (600) begin
                @(negedge pclk);
                cmd_valid = ($urandom_range(0, 1) == 1);
                cmd_write = ($urandom_range(0, 1) == 1);
                cmd_addr  = AW'($urandom);
                cmd_wdata = DW'($urandom);
            end
        end
        cmd_valid = 1'b0;
        rs_mode = 0;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin @(negedge pclk); n++; end
        check("final_drain_busy", 32'(busy), 32'd0);
        @(negedge pclk);
        check("rsp_count", 32'(dut_rsp_cnt), 32'(m_resp_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
